// File: rtl/vga_arb_pkg.sv
// ---------------------------------------------------------------------------
// vga_arb_pkg
//   Shared definitions for the VGA pixel-write arbiter slice.
//
//   Contents:
//     X_WIDTH_DEF / Y_WIDTH_DEF  default coordinate widths (320x240 dots)
//     COLOUR_WIDTH_DEF           default colour width (1 bit per channel)
//     X_MAX_DEF / Y_MAX_DEF      default screen dimensions in dots
//     NUM_REQ                    number of pixel-write requesters
//     arb_state_t                arbiter FSM state encoding (IDLE, CLEAR)
//     rr_pick()                  round-robin winner selection helper
// ---------------------------------------------------------------------------
package vga_arb_pkg;

  localparam int X_WIDTH_DEF      = 9;
  localparam int Y_WIDTH_DEF      = 8;
  localparam int COLOUR_WIDTH_DEF = 3;
  localparam int X_MAX_DEF        = 320;
  localparam int Y_MAX_DEF        = 240;
  localparam int NUM_REQ          = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

  // Pick the requester to grant. A lone requester always wins; when both
  // request, the favoured one (the one not granted last) wins.
  function automatic logic rr_pick(input logic [NUM_REQ-1:0] req,
                                   input logic               favour);
    logic pick;
    pick = 1'b0;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = favour;
      default: pick = 1'b0;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/vga_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// vga_write_arbiter_if
//   Request / write-port bundle between the pixel requesters, the arbiter and
//   the video memory write port.
//
//   Signals:
//     req        [2]               per-requester pixel-write request
//     req_x      [2*X_WIDTH]       packed x coordinates, requester i in slice i
//     req_y      [2*Y_WIDTH]       packed y coordinates
//     req_colour [2*COLOUR_WIDTH]  packed colours
//     ack        [2]               one-cycle grant pulse per requester
//     x, y, colour, plot           video memory write port
//
//   Modports:
//     master  requester / memory side (drives requests, observes grants)
//     slave   arbiter side
// ---------------------------------------------------------------------------
interface vga_write_arbiter_if
  import vga_arb_pkg::*;
#(
  parameter int X_WIDTH      = X_WIDTH_DEF,
  parameter int Y_WIDTH      = Y_WIDTH_DEF,
  parameter int COLOUR_WIDTH = COLOUR_WIDTH_DEF
) ();

  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*X_WIDTH-1:0]      req_x;
  logic [NUM_REQ*Y_WIDTH-1:0]      req_y;
  logic [NUM_REQ*COLOUR_WIDTH-1:0] req_colour;
  logic [NUM_REQ-1:0]              ack;

  logic [X_WIDTH-1:0]              x;
  logic [Y_WIDTH-1:0]              y;
  logic [COLOUR_WIDTH-1:0]         colour;
  logic                            plot;

  modport master (
    output req, req_x, req_y, req_colour,
    input  ack, x, y, colour, plot
  );

  modport slave (
    input  req, req_x, req_y, req_colour,
    output ack, x, y, colour, plot
  );

endinterface

// File: rtl/vga_clear_scanner.sv
// ---------------------------------------------------------------------------
// vga_clear_scanner
//   Raster sweep counter for the full-screen clear. The counter holds the
//   pixel currently presented on the write port; next_x/next_y give the pixel
//   that follows it (x fastest), and last flags the final pixel
//   (X_MAX-1, Y_MAX-1).
//
//   Ports:
//     clock    system clock
//     resetn   asynchronous active-low reset
//     start    load the counter with pixel (0,0)
//     advance  step the counter to next_x/next_y
//     next_x   x of the pixel after the current one
//     next_y   y of the pixel after the current one
//     last     current pixel is the final one of the frame
// ---------------------------------------------------------------------------
module vga_clear_scanner
  import vga_arb_pkg::*;
#(
  parameter int X_WIDTH = X_WIDTH_DEF,
  parameter int Y_WIDTH = Y_WIDTH_DEF,
  parameter int X_MAX   = X_MAX_DEF,
  parameter int Y_MAX   = Y_MAX_DEF
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               advance,
  output logic [X_WIDTH-1:0] next_x,
  output logic [Y_WIDTH-1:0] next_y,
  output logic               last
);

  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(X_MAX - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(Y_MAX - 1);

  logic [X_WIDTH-1:0] cnt_x_reg;
  logic [Y_WIDTH-1:0] cnt_y_reg;

  assign last = (cnt_x_reg == X_LAST) && (cnt_y_reg == Y_LAST);

  always_comb begin
    next_x = cnt_x_reg + X_WIDTH'(1);
    next_y = cnt_y_reg;
    if (cnt_x_reg == X_LAST) begin
      next_x = '0;
      next_y = cnt_y_reg + Y_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_x_reg <= '0;
      cnt_y_reg <= '0;
    end else if (start) begin
      cnt_x_reg <= '0;
      cnt_y_reg <= '0;
    end else if (advance) begin
      cnt_x_reg <= next_x;
      cnt_y_reg <= next_y;
    end
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// ---------------------------------------------------------------------------
// vga_write_arbiter
//   Arbitrates two pixel-write requesters onto a single video memory write
//   port with round-robin fairness, and optionally sweeps the whole screen
//   with a fill colour (clear engine).
//
//   Optional feature: define VGA_WRITE_ARBITER_CLEAR_EN to compile in the
//   clear engine. Without it, clear_start/clear_colour are ignored and
//   busy/clear_done are tied to 0.
//
//   Ports:
//     clock         system clock, rising edge
//     resetn        asynchronous active-low reset
//     bus           request bundle + write port (slave modport)
//     clear_start   pulse: start a full-screen clear (IDLE only)
//     clear_colour  fill colour, sampled with clear_start
//     busy          high while the clear is sweeping
//     clear_done    one-cycle pulse after the last clear pixel
//
//   All outputs come straight from registers; every write-port update lands
//   one cycle after the request/start that caused it.
// ---------------------------------------------------------------------------
module vga_write_arbiter
  import vga_arb_pkg::*;
#(
  parameter int X_WIDTH      = X_WIDTH_DEF,
  parameter int Y_WIDTH      = Y_WIDTH_DEF,
  parameter int COLOUR_WIDTH = COLOUR_WIDTH_DEF,
  parameter int X_MAX        = X_MAX_DEF,
  parameter int Y_MAX        = Y_MAX_DEF
) (
  input  logic                    clock,
  input  logic                    resetn,
  vga_write_arbiter_if.slave      bus,
  input  logic                    clear_start,
  input  logic [COLOUR_WIDTH-1:0] clear_colour,
  output logic                    busy,
  output logic                    clear_done
);

  // Unpacked per-requester views of the packed request buses.
  logic [X_WIDTH-1:0]      req_x_arr      [NUM_REQ];
  logic [Y_WIDTH-1:0]      req_y_arr      [NUM_REQ];
  logic [COLOUR_WIDTH-1:0] req_colour_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_x_arr[gi]      = bus.req_x[gi*X_WIDTH +: X_WIDTH];
    assign req_y_arr[gi]      = bus.req_y[gi*Y_WIDTH +: Y_WIDTH];
    assign req_colour_arr[gi] = bus.req_colour[gi*COLOUR_WIDTH +: COLOUR_WIDTH];
  end

  arb_state_t              state_reg,  state_next;
  logic [X_WIDTH-1:0]      x_reg,      x_next;
  logic [Y_WIDTH-1:0]      y_reg,      y_next;
  logic [COLOUR_WIDTH-1:0] colour_reg, colour_next;
  logic                    plot_reg,   plot_next;
  logic [NUM_REQ-1:0]      ack_reg,    ack_next;
  // Requester favoured when both request; 0 after reset, never touched by
  // a clear.
  logic                    prio_reg,   prio_next;

  logic                    winner;

  assign winner = rr_pick(bus.req, prio_reg);

`ifdef VGA_WRITE_ARBITER_CLEAR_EN
  logic                    busy_reg,   busy_next;
  logic                    done_reg,   done_next;
  logic [COLOUR_WIDTH-1:0] fill_reg,   fill_next;
  logic                    scan_start, scan_advance, scan_last;
  logic [X_WIDTH-1:0]      scan_next_x;
  logic [Y_WIDTH-1:0]      scan_next_y;

  vga_clear_scanner #(
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH),
    .X_MAX   (X_MAX),
    .Y_MAX   (Y_MAX)
  ) u_scanner (
    .clock   (clock),
    .resetn  (resetn),
    .start   (scan_start),
    .advance (scan_advance),
    .next_x  (scan_next_x),
    .next_y  (scan_next_y),
    .last    (scan_last)
  );
`else
  // Clear inputs exist for port compatibility only in this build.
  logic unused_clear;
  assign unused_clear = ^{clear_start, clear_colour};
`endif

  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    colour_next = colour_reg;
    plot_next   = 1'b0;
    ack_next    = '0;
    prio_next   = prio_reg;
`ifdef VGA_WRITE_ARBITER_CLEAR_EN
    busy_next    = 1'b0;
    done_next    = 1'b0;
    fill_next    = fill_reg;
    scan_start   = 1'b0;
    scan_advance = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
`ifdef VGA_WRITE_ARBITER_CLEAR_EN
        // A clear start pre-empts any request presented in the same cycle;
        // pixel (0,0) goes out immediately so plot never gaps.
        if (clear_start) begin
          state_next  = CLEAR;
          x_next      = '0;
          y_next      = '0;
          colour_next = clear_colour;
          fill_next   = clear_colour;
          plot_next   = 1'b1;
          busy_next   = 1'b1;
          scan_start  = 1'b1;
        end else
`endif
        if (|bus.req) begin
          x_next      = req_x_arr[winner];
          y_next      = req_y_arr[winner];
          colour_next = req_colour_arr[winner];
          plot_next   = 1'b1;
          ack_next    = winner ? 2'b10 : 2'b01;
          prio_next   = ~winner;
        end
      end

`ifdef VGA_WRITE_ARBITER_CLEAR_EN
      CLEAR: begin
        // The scanner tracks the pixel now on the write port; once that is
        // the last one, the following cycle reports completion.
        if (scan_last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          x_next       = scan_next_x;
          y_next       = scan_next_y;
          colour_next  = fill_reg;
          plot_next    = 1'b1;
          busy_next    = 1'b1;
          scan_advance = 1'b1;
        end
      end
`endif

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      colour_reg <= '0;
      plot_reg   <= 1'b0;
      ack_reg    <= '0;
      prio_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      colour_reg <= colour_next;
      plot_reg   <= plot_next;
      ack_reg    <= ack_next;
      prio_reg   <= prio_next;
    end
  end

`ifdef VGA_WRITE_ARBITER_CLEAR_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      fill_reg <= '0;
    end else begin
      busy_reg <= busy_next;
      done_reg <= done_next;
      fill_reg <= fill_next;
    end
  end

  assign busy       = busy_reg;
  assign clear_done = done_reg;
`else
  assign busy       = 1'b0;
  assign clear_done = 1'b0;
`endif

  assign bus.x      = x_reg;
  assign bus.y      = y_reg;
  assign bus.colour = colour_reg;
  assign bus.plot   = plot_reg;
  assign bus.ack    = ack_reg;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_write_arbiter
//   Scoreboard bench for vga_write_arbiter. The stimulus process drives the
//   inputs on the falling edge, asks a behavioural model what the write port
//   must show after the next rising edge and queues it; the monitor pops and
//   compares one entry per cycle just after each rising edge.
//   Clear-engine scenarios run when VGA_WRITE_ARBITER_CLEAR_EN is defined.
// ---------------------------------------------------------------------------
module tb_vga_write_arbiter;

  localparam int XW   = 9;
  localparam int YW   = 8;
  localparam int CW   = 3;
  localparam int XM   = 320;
  localparam int YM   = 240;
  localparam int NPIX = XM * YM;

`ifdef VGA_WRITE_ARBITER_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          resetn;
  logic          clear_start;
  logic [CW-1:0] clear_colour;
  logic          busy;
  logic          clear_done;

  vga_write_arbiter_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .COLOUR_WIDTH(CW)) bus ();

  vga_write_arbiter #(
    .X_WIDTH(XW), .Y_WIDTH(YW), .COLOUR_WIDTH(CW), .X_MAX(XM), .Y_MAX(YM)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .bus          (bus.slave),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .busy         (busy),
    .clear_done   (clear_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]    ack;
    logic          plot;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
    logic          busy;
    logic          done;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  bit   mon_en = 1'b0;

  // ---------------- behavioural model ----------------
  int m_favour;      // requester that wins a tie
  int m_left;        // clear pixels still to be written
  bit m_done_due;    // completion pulse owed next cycle
  int m_x, m_y, m_c; // last value written to the port
  int m_fill;

  function automatic void model_reset();
    m_favour = 0; m_left = 0; m_done_due = 0;
    m_x = 0; m_y = 0; m_c = 0; m_fill = 0;
  endfunction

  function automatic obs_t model_step(input logic [1:0] r,
                                      input logic [2*XW-1:0] rx,
                                      input logic [2*YW-1:0] ry,
                                      input logic [2*CW-1:0] rc,
                                      input bit cs, input int cc);
    obs_t e;
    int   idx, w;
    e = '0;
    if (m_left > 0) begin
      idx = NPIX - m_left;
      m_x = idx % XM; m_y = idx / XM; m_c = m_fill;
      e.plot = 1'b1; e.busy = 1'b1;
      m_left--;
      if (m_left == 0) m_done_due = 1;
    end else if (m_done_due) begin
      e.done = 1'b1;
      m_done_due = 0;
    end else if (CLR_EN && cs) begin
      m_fill = cc;
      m_x = 0; m_y = 0; m_c = cc;
      e.plot = 1'b1; e.busy = 1'b1;
      m_left = NPIX - 1;
    end else if (r != 2'b00) begin
      if (r == 2'b11) w = m_favour;
      else            w = (r == 2'b10) ? 1 : 0;
      m_favour = 1 - w;
      m_x = int'(rx[w*XW +: XW]);
      m_y = int'(ry[w*YW +: YW]);
      m_c = int'(rc[w*CW +: CW]);
      e.plot = 1'b1;
      e.ack  = (w == 1) ? 2'b10 : 2'b01;
    end
    e.x = XW'(m_x); e.y = YW'(m_y); e.colour = CW'(m_c);
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [1:0] r, input logic [2*XW-1:0] rx,
                       input logic [2*YW-1:0] ry, input logic [2*CW-1:0] rc,
                       input bit cs, input logic [CW-1:0] cc);
    @(negedge clock);
    bus.req = r; bus.req_x = rx; bus.req_y = ry; bus.req_colour = rc;
    clear_start = cs; clear_colour = cc;
    exp_q.push_back(model_step(r, rx, ry, rc, cs, int'(cc)));
    mon_en = 1'b1;
  endtask

  task automatic drive_rand(input logic [1:0] r, input bit cs);
    logic [2*XW-1:0] rx;
    logic [2*YW-1:0] ry;
    logic [2*CW-1:0] rc;
    logic [CW-1:0]   cc;
    rx = {XW'($urandom_range(0, XM-1)), XW'($urandom_range(0, XM-1))};
    ry = {YW'($urandom_range(0, YM-1)), YW'($urandom_range(0, YM-1))};
    rc = (2*CW)'($urandom);
    cc = CW'($urandom);
    drive(r, rx, ry, rc, cs, cc);
  endtask

  task automatic check_zero(input string name);
    logic [XW+YW+CW+5:0] got;
    got = {bus.ack, bus.plot, bus.x, bus.y, bus.colour, busy, clear_done};
    checks++;
    if (got !== '0) begin
      fails++;
      $display("FAIL %s: outputs ack=%b plot=%b x=%0d y=%0d colour=%0d busy=%b done=%b, required all zero",
               name, bus.ack, bus.plot, bus.x, bus.y, bus.colour, busy, clear_done);
    end
  endtask

  task automatic reset_pulse(input string name);
    @(negedge clock);
    #2;
    resetn = 1'b0;
    mon_en = 1'b0;
    #1;
    check_zero(name);
    exp_q.delete();
    model_reset();
    bus.req = 2'b00;
    clear_start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_zero({name, "_held"});
    @(negedge clock);
    resetn = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    obs_t e, got;
    forever begin
      @(posedge clock);
      #1;
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {bus.ack, bus.plot, bus.x, bus.y, bus.colour, busy, clear_done};
        checks++;
        if (got !== e) begin
          fails++;
          $display("FAIL cycle@%0t: got ack=%b plot=%b x=%0d y=%0d colour=%0d busy=%b done=%b, required ack=%b plot=%b x=%0d y=%0d colour=%0d busy=%b done=%b",
                   $time, got.ack, got.plot, got.x, got.y, got.colour, got.busy, got.done,
                   e.ack, e.plot, e.x, e.y, e.colour, e.busy, e.done);
        end
        if (got.ack != 2'b00)
          $display("txn grant ack=%b x=%0d y=%0d colour=%0d", got.ack, got.x, got.y, got.colour);
        if (got.done)
          $display("txn clear_done at %0t", $time);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    resetn = 1'b1;
    bus.req = '0; bus.req_x = '0; bus.req_y = '0; bus.req_colour = '0;
    clear_start = 1'b0; clear_colour = '0;
    model_reset();
    #1 resetn = 1'b0;
    #1 check_zero("reset_initial");
    repeat (2) @(posedge clock);
    #1 check_zero("reset_initial_held");
    @(negedge clock);
    resetn = 1'b1;

    // Single requester 0 with fixed data.
    drive(2'b01, {9'd0, 9'd5}, {8'd0, 8'd7}, {3'd0, 3'b101}, 1'b0, '0);
    drive(2'b00, '0, '0, '0, 1'b0, '0);

    // Both requesting, held four cycles, from a fresh pointer.
    reset_pulse("reset_before_rr");
    for (int i = 0; i < 4; i++)
      drive(2'b11, {9'd100, 9'd10}, {8'd200, 8'd20}, {3'b110, 3'b001}, 1'b0, '0);
    drive(2'b00, '0, '0, '0, 1'b0, '0);

    // Random traffic; clear_start only sprinkled where it must be ignored.
    for (int i = 0; i < 2000; i++)
      drive_rand(2'($urandom), CLR_EN ? 1'b0 : ($urandom_range(0, 7) == 0));

`ifdef VGA_WRITE_ARBITER_CLEAR_EN
    // Full clear colliding with a request; requests and clear_start keep
    // arriving during the sweep and must be ignored.
    drive(2'b01, {9'd0, 9'd33}, {8'd0, 8'd44}, {3'd0, 3'd7}, 1'b1, 3'b010);
    for (int i = 0; i < NPIX + 4; i++)
      drive(2'b01, {9'd0, 9'd33}, {8'd0, 8'd44}, {3'd0, 3'd7},
            ($urandom_range(0, 15) == 0), CW'($urandom));
    for (int i = 0; i < 50; i++)
      drive_rand(2'($urandom), 1'b0);

    // Reset in the middle of a clear.
    drive(2'b00, '0, '0, '0, 1'b1, 3'b111);
    for (int i = 0; i < 1000; i++)
      drive_rand(2'($urandom), 1'b0);
    reset_pulse("reset_mid_clear");
`else
    for (int i = 0; i < 100; i++)
      drive_rand(2'($urandom), 1'b1);
    reset_pulse("reset_mid_traffic");
`endif

    drive(2'b10, {9'd17, 9'd0}, {8'd9, 8'd0}, {3'd4, 3'd0}, 1'b0, '0);
    for (int i = 0; i < 200; i++)
      drive_rand(2'($urandom), 1'b0);
    drive(2'b00, '0, '0, '0, 1'b0, '0);
    drive(2'b00, '0, '0, '0, 1'b0, '0);

    repeat (2) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vga_write_arbiter.md
VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 Parameter X_WIDTH, default 9, width of the x coordinate (320x240 dots).
REQ-002 Parameter Y_WIDTH, default 8, width of the y coordinate.
REQ-003 Parameter COLOUR_WIDTH, default 3, pixel colour width (1 bit per channel).
REQ-004 Parameter X_MAX, default 320, number of dot columns.
REQ-005 Parameter Y_MAX, default 240, number of dot rows.
REQ-006 clock  input  1  system clock; all state changes on its rising edge.
REQ-007 resetn  input  1  reset; asynchronous, active-low.
REQ-008 req  input  2  per-requester pixel-write request, one bit per requester.
REQ-009 req_x  input  2*X_WIDTH  packed x coordinates; requester i in slice i.
REQ-010 req_y  input  2*Y_WIDTH  packed y coordinates.
REQ-011 req_colour  input  2*COLOUR_WIDTH  packed colours.
REQ-012 ack  output  2  one-cycle grant pulse per requester.
REQ-013 clear_start  input  1  pulse that starts a full-screen clear.
REQ-014 clear_colour  input  COLOUR_WIDTH  fill colour, sampled on the clear_start cycle.
REQ-015 x  output  X_WIDTH  write coordinate to the video memory write port.
REQ-016 y  output  Y_WIDTH  write coordinate.
REQ-017 colour  output  COLOUR_WIDTH  write colour.
REQ-018 plot  output  1  write enable; one pixel written per cycle it is high.
REQ-019 busy  output  1  high while a clear is in progress.
REQ-020 clear_done  output  1  one-cycle pulse when a clear completes.

Function
REQ-021 All outputs SHALL be registered.
REQ-022 FSM states SHALL be IDLE and CLEAR.
REQ-023 IDLE, no clear_start, req nonzero: winner registered to x/y/colour; plot and ack[winner] high the next cycle (latency 1).
REQ-024 Arbitration SHALL be round-robin: with both requesting, the requester not granted last wins; single requester always wins.
REQ-025 Requester SHALL hold data stable while req is high; req still high in the ack cycle counts as a new request with the data then presented, giving up to one pixel per cycle.
REQ-026 IDLE, no request: plot=0, ack=0; x/y/colour hold their values.
REQ-027 clear_start in IDLE SHALL enter CLEAR and take priority over simultaneous requests; those requests receive no ack.
REQ-028 CLEAR SHALL emit plot every cycle, x fastest from 0..X_MAX-1, then y 0..Y_MAX-1, colour=latched clear_colour: X_MAX*Y_MAX cycles.
REQ-029 During CLEAR, ack SHALL stay 0, and clear_start SHALL be ignored.
REQ-030 The cycle after the last pixel (X_MAX-1,Y_MAX-1) plots: clear_done=1 for one cycle, busy=0, return to IDLE.
REQ-031 busy SHALL be high from the cycle after clear_start through the last clear pixel's plot cycle.
REQ-032 Round-robin pointer SHALL be unchanged by a clear.

Reset
REQ-033 resetn low SHALL immediately force IDLE, x=0, y=0, colour=0, plot=0, ack=0, busy=0, clear_done=0, and pointer favouring requester 0; this applies mid-clear too, and the clear is abandoned.

Configuration
REQ-034 Macro VGA_WRITE_ARBITER_CLEAR_EN defined: clear engine compiled in as specified.
REQ-035 Macro undefined: CLEAR state and scanner are omitted. clear_start and clear_colour remain as ports and are ignored. busy and clear_done are tied to 0.

Structure
REQ-036 Package vga_arb_pkg SHALL hold the state encoding and the default width and dimension constants.
REQ-037 Sub-module vga_clear_scanner SHALL implement the x/y sweep counter with a last-pixel flag.

Verification
REQ-038 req=01, x=5, y=7, colour=3'b101 -> next cycle plot=1, ack=01, x=5, y=7, colour=101.
REQ-039 req=11 held 4 cycles -> ack sequence 01,10,01,10 with matching data; plot high throughout.
REQ-040 clear_start with clear_colour=3'b010 and req=01 in the same cycle -> 76800 consecutive plots covering (0,0)..(319,239), ack=00 throughout, then clear_done pulse, then ack=01.
REQ-041 resetn low at clear pixel 1000 -> all outputs 0 immediately; after release, the first req=10 is granted normally.
REQ-042 Build without VGA_WRITE_ARBITER_CLEAR_EN and pulse clear_start -> busy=0, no clear plots; requests continue to be granted.
